// File: rtl/execute_regfile.sv
// execute_regfile: combinational execute stage over a 16-entry register file, PC and CPSR.
// Define EXEC_DEBUG_PORTS_EN to expose wb_rd_out and wb_cpsr_out.
module execute_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [3:0]  cond,
    input  logic [17:0] imm,
    input  logic [21:0] mem,
    input  logic        is_alu_op,
    input  logic        is_not_op,
    input  logic        is_cmp_op,
    input  logic        is_jmp_op,
    input  logic        is_ld_op,
    input  logic        is_str_op,
    input  logic        is_call_op,
    input  logic        is_ret_op,
    input  logic        is_src2_imm,
    input  logic [31:0] if_pc_in,
    output logic [31:0] if_pc_out,
    input  logic [3:0]  wb_rd_num,
    input  logic        wb_rd_write_en,
    input  logic [31:0] wb_rd_in,
    input  logic        wb_cpsr_write_en,
    input  logic [31:0] wb_cpsr_in,
    output logic [31:0] result,
    output logic [31:0] cpsr_passthrough,
    output logic        taken,
    output logic [31:0] pc_rel,
    output logic [3:0]  rd_num_passthrough,
    output logic [31:0] rd_val_passthrough,
    output logic [31:0] mem_passthrough,
    output logic        is_alu_op_passthrough,
    output logic        is_cmp_op_passthrough,
    output logic        is_ld_op_passthrough,
`ifdef EXEC_DEBUG_PORTS_EN
    output logic [31:0] wb_rd_out,
    output logic [31:0] wb_cpsr_out,
`endif
    output logic        is_str_op_passthrough
);
    logic [31:0] regs [16];
    logic [31:0] pc, cpsr;
    logic [31:0] rd_val, rs_val, rt_val, src2, sext_imm, sext_mem, alu_res, diff;
    logic        n, z, v, cond_ok, branch, unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            pc   <= '0;
            cpsr <= '0;
        end else begin
            pc <= if_pc_in;
            if (wb_rd_write_en) regs[wb_rd_num] <= wb_rd_in;
            if (wb_cpsr_write_en) cpsr <= wb_cpsr_in;
        end
    end

    assign rd_val   = regs[rd];
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign sext_imm = {{14{imm[17]}}, imm};
    assign sext_mem = {{10{mem[21]}}, mem};
    assign src2     = is_src2_imm ? sext_imm : rt_val;
    // Operation is selected by opcode[5:1]; opcode[0] only distinguishes encodings upstream.
    assign unused   = ^{is_not_op, opcode[0]};

    always_comb begin
        alu_res = '0;
        case (opcode[5:1])
            5'b00000: alu_res = src2;
            5'b00010: alu_res = {rd_val[31:16], imm[15:0]};
            5'b00011: alu_res = {imm[15:0], rd_val[15:0]};
            5'b00100: alu_res = rs_val + src2;
            5'b00101: alu_res = rs_val - src2;
            5'b00110: alu_res = rs_val & src2;
            5'b00111: alu_res = rs_val | src2;
            5'b01000: alu_res = rs_val ^ src2;
            5'b01001: alu_res = rs_val << src2[4:0];
            5'b01010: alu_res = ~src2;
            5'b01011: alu_res = rs_val >> src2[4:0];
            5'b01100: alu_res = $signed(rs_val) >>> src2[4:0];
            default:  alu_res = '0;
        endcase
    end

    assign diff = rs_val - src2;
    assign n = cpsr[31];
    assign z = cpsr[30];
    assign v = cpsr[28];

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = 1'b1;
            4'b0001: cond_ok = z;
            4'b0010: cond_ok = n == v;
            4'b0011: cond_ok = !z && n == v;
            4'b0100: cond_ok = z || n != v;
            4'b0101: cond_ok = n != v;
            4'b0110: cond_ok = !z;
            default: cond_ok = 1'b0;
        endcase
    end

    assign branch = is_call_op || is_ret_op || is_jmp_op;
    assign taken  = (is_call_op || is_ret_op) ? 1'b1 : is_jmp_op ? cond_ok : 1'b0;
    assign pc_rel = is_call_op ? sext_mem : is_ret_op ? regs[14] - pc : is_jmp_op ? sext_mem : '0;
    assign result = is_call_op ? pc + 32'd1 : is_alu_op ? alu_res : '0;
    // Borrow-style carry: C set when the subtraction underflows unsigned.
    assign cpsr_passthrough = (is_cmp_op && !branch) ?
        {diff[31], diff == '0, rs_val < src2,
         (rs_val[31] != src2[31]) && (diff[31] != rs_val[31]), cpsr[27:0]} : cpsr;

    assign if_pc_out             = pc;
    assign rd_num_passthrough    = is_call_op ? 4'd14 : rd;
    assign rd_val_passthrough    = rd_val;
    assign mem_passthrough       = {10'd0, mem};
    assign is_alu_op_passthrough = is_alu_op || is_call_op;
    assign is_cmp_op_passthrough = is_cmp_op;
    assign is_ld_op_passthrough  = is_ld_op;
    assign is_str_op_passthrough = is_str_op;
`ifdef EXEC_DEBUG_PORTS_EN
    assign wb_rd_out   = regs[wb_rd_num];
    assign wb_cpsr_out = cpsr;
`endif
endmodule

// File: tb/tb_execute_regfile.sv
// tb_execute_regfile: directed vectors with a queue-based scoreboard for execute_regfile.
module tb_execute_regfile;
    logic        clk = 0, reset;
    logic [5:0]  opcode;
    logic [3:0]  rd, rs, rt, cond, wb_rd_num, rd_num_passthrough;
    logic [17:0] imm;
    logic [21:0] mem;
    logic        is_alu_op, is_not_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op;
    logic        is_call_op, is_ret_op, is_src2_imm, wb_rd_write_en, wb_cpsr_write_en;
    logic [31:0] if_pc_in, if_pc_out, wb_rd_in, wb_cpsr_in, result, cpsr_passthrough;
    logic [31:0] pc_rel, rd_val_passthrough, mem_passthrough;
    logic        taken, is_alu_op_passthrough, is_cmp_op_passthrough;
    logic        is_ld_op_passthrough, is_str_op_passthrough;

    execute_regfile dut (
        .clk(clk), .reset(reset), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .cond(cond), .imm(imm), .mem(mem), .is_alu_op(is_alu_op), .is_not_op(is_not_op),
        .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op), .is_ld_op(is_ld_op),
        .is_str_op(is_str_op), .is_call_op(is_call_op), .is_ret_op(is_ret_op),
        .is_src2_imm(is_src2_imm), .if_pc_in(if_pc_in), .if_pc_out(if_pc_out),
        .wb_rd_num(wb_rd_num), .wb_rd_write_en(wb_rd_write_en), .wb_rd_in(wb_rd_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in), .result(result),
        .cpsr_passthrough(cpsr_passthrough), .taken(taken), .pc_rel(pc_rel),
        .rd_num_passthrough(rd_num_passthrough), .rd_val_passthrough(rd_val_passthrough),
        .mem_passthrough(mem_passthrough), .is_alu_op_passthrough(is_alu_op_passthrough),
        .is_cmp_op_passthrough(is_cmp_op_passthrough),
        .is_ld_op_passthrough(is_ld_op_passthrough),
        .is_str_op_passthrough(is_str_op_passthrough)
    );

    always #5 clk = ~clk;

    typedef enum int {F_RES, F_CPSR, F_TAKEN, F_PCREL, F_RDNUM, F_RDVAL, F_MEM, F_STR, F_PC, F_ALUP} fld_t;
    typedef struct {
        string       name;
        fld_t        f;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    function automatic logic [31:0] act(fld_t f);
        case (f)
            F_RES:   return result;
            F_CPSR:  return cpsr_passthrough;
            F_TAKEN: return {31'd0, taken};
            F_PCREL: return pc_rel;
            F_RDNUM: return {28'd0, rd_num_passthrough};
            F_RDVAL: return rd_val_passthrough;
            F_MEM:   return mem_passthrough;
            F_STR:   return {31'd0, is_str_op_passthrough};
            F_PC:    return if_pc_out;
            default: return {31'd0, is_alu_op_passthrough};
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = act(e.f);
            total++;
            if (a !== e.v) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, a, e.v);
            end
        end
    end

    task automatic chk(string n, fld_t f, logic [31:0] v);
        q.push_back('{n, f, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        opcode = 0; rd = 0; rs = 0; rt = 0; cond = 0; imm = 0; mem = 0;
        is_alu_op = 0; is_not_op = 0; is_cmp_op = 0; is_jmp_op = 0; is_ld_op = 0;
        is_str_op = 0; is_call_op = 0; is_ret_op = 0; is_src2_imm = 0;
        wb_rd_num = 0; wb_rd_write_en = 0; wb_rd_in = 0; wb_cpsr_write_en = 0; wb_cpsr_in = 0;
    endtask

    task automatic wr(logic [3:0] num, logic [31:0] val);
        clr();
        wb_rd_num = num; wb_rd_in = val; wb_rd_write_en = 1;
        step();
        wb_rd_write_en = 0;
    endtask

    task automatic alu(logic [5:0] op, logic [3:0] d, logic [3:0] s, logic [3:0] t,
                       logic im, logic [17:0] iv);
        clr();
        is_alu_op = 1; opcode = op; rd = d; rs = s; rt = t; is_src2_imm = im; imm = iv;
    endtask

    task automatic cmp(logic [3:0] s, logic [3:0] t, logic im, logic [17:0] iv);
        clr();
        is_cmp_op = 1; rs = s; rt = t; is_src2_imm = im; imm = iv;
    endtask

    logic [3:0] jc [7] = '{4'b0000, 4'b0010, 4'b0011, 4'b0110, 4'b0001, 4'b0100, 4'b0101};
    logic       jt [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 0; if_pc_in = 0;
        clr();
        step();
        chk("rst_pc", F_PC, 0);
        chk("rst_cpsr", F_CPSR, 0);
        step();
        reset = 1;
        alu(6'b001001, 1, 2, 3, 0, 0);
        chk("add0_res", F_RES, 0);
        chk("add0_rd", F_RDNUM, 1);
        step();
        alu(6'b000101, 6, 0, 0, 1, 7);
        chk("movlo16", F_RES, 32'h7);
        step();
        alu(6'b000111, 8, 0, 0, 1, 9);
        chk("movhi16", F_RES, 32'h0009_0000);
        step();
        alu(6'b010101, 1, 0, 0, 1, 1);
        chk("noti", F_RES, 32'hFFFF_FFFE);
        step();
        cmp(2, 3, 0, 0);
        chk("cmp_zero", F_CPSR, 32'h4000_0000);
        step();
        cmp(4, 0, 1, 5);
        chk("cmp_imm5", F_CPSR, 32'hA000_0000);
        step();
        for (int i = 0; i < 7; i++) begin
            clr();
            is_jmp_op = 1; cond = jc[i]; mem = 7;
            chk($sformatf("jmp_c%0d_taken", jc[i]), F_TAKEN, {31'd0, jt[i]});
            if (jt[i]) chk($sformatf("jmp_c%0d_rel", jc[i]), F_PCREL, 7);
            step();
        end
        wr(10, 32'h1234);
        clr();
        is_str_op = 1; rd = 10; mem = 11;
        chk("str_val", F_RDVAL, 32'h1234);
        chk("str_mem", F_MEM, 11);
        chk("str_flag", F_STR, 1);
        step();
        wr(2, 10);
        wr(3, 3);
        alu(6'b001001, 1, 2, 3, 0, 0);
        chk("add", F_RES, 13);
        step();
        alu(6'b001011, 1, 2, 3, 0, 0);
        chk("sub", F_RES, 7);
        step();
        alu(6'b010001, 1, 2, 3, 0, 0);
        chk("xor", F_RES, 9);
        step();
        alu(6'b010011, 1, 2, 0, 1, 2);
        chk("lsli", F_RES, 40);
        step();
        cmp(3, 2, 0, 0);
        chk("cmp_neg", F_CPSR, 32'hA000_0000);
        step();
        cmp(2, 2, 0, 0);
        chk("cmp_eq", F_CPSR, 32'h4000_0000);
        step();
        clr();
        wb_cpsr_in = 32'h4000_0000; wb_cpsr_write_en = 1;
        step();
        clr();
        is_jmp_op = 1; cond = 4'b0001; mem = 7;
        chk("jeq_z_taken", F_TAKEN, 1);
        chk("cpsr_hold", F_CPSR, 32'h4000_0000);
        step();
        clr();
        is_jmp_op = 1; cond = 4'b0110;
        chk("jne_z_taken", F_TAKEN, 0);
        if_pc_in = 100;
        step();
        clr();
        chk("pc", F_PC, 100);
        is_call_op = 1; mem = 22'h3F_FFFE;
        chk("call_res", F_RES, 101);
        chk("call_rel", F_PCREL, 32'hFFFF_FFFE);
        chk("call_taken", F_TAKEN, 1);
        chk("call_rd", F_RDNUM, 14);
        chk("call_alup", F_ALUP, 1);
        step();
        clr();
        is_ret_op = 1;
        chk("ret0_rel", F_PCREL, 32'hFFFF_FF9C);
        chk("ret_taken", F_TAKEN, 1);
        step();
        wr(14, 150);
        clr();
        is_ret_op = 1;
        chk("ret_rel", F_PCREL, 50);
        step();
        clr();
        wb_rd_num = 10; wb_rd_in = 32'h5555;
        step();
        is_str_op = 1; rd = 10;
        chk("nowrite", F_RDVAL, 32'h1234);
        step();
        reset = 0;
        chk("rst_r10", F_RDVAL, 0);
        chk("rst_cpsr2", F_CPSR, 0);
        chk("rst_pc2", F_PC, 0);
        step();
        wr(10, 32'h77);
        reset = 1;
        clr();
        rd = 10;
        chk("rst_wr_ignored", F_RDVAL, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        step();
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
